// File: rtl/cub_crbr_pkg.sv
// Shared types and default sizing for the cub_crbr crossbar receive block.
package cub_crbr_pkg;

    localparam int DEF_DWID       = 32;
    localparam int DEF_CH_IN      = 5;
    localparam int DEF_CH_OUT     = 5;
    localparam int DEF_FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        LOAD  = 2'd2
    } crbr_state_e;

endpackage

// File: rtl/cub_crbr_fifo.sv
// Per-sink synchronous FIFO; FIFO_DEPTH must be a power of two so the pointers
// wrap naturally at their bit width.
module cub_crbr_fifo
    import cub_crbr_pkg::*;
#(
    parameter int DWID       = DEF_DWID,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push_i,
    input  logic [DWID-1:0] data_i,
    input  logic            pop_i,
    output logic            full_o,
    output logic            empty_o,
    output logic [DWID-1:0] head_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DWID-1:0]  mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
        rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
        count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is deliberately not reset; head_o is forced to 0 while empty instead.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/cub_crbr_rx.sv
// Crossbar receive stage: routes sources to per-sink FIFOs through an active
// mask that is swapped only after every sink FIFO has drained.
module cub_crbr_rx
    import cub_crbr_pkg::*;
#(
    parameter int DWID       = DEF_DWID,
    parameter int CH_IN      = DEF_CH_IN,
    parameter int CH_OUT     = DEF_CH_OUT,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [CH_OUT-1:0][CH_IN-1:0]  cub_crbr_cfg_bitmask,
    input  logic                          cub_crbr_cfg_load,
    output logic                          cub_crbr_cfg_busy,
    input  logic [CH_IN-1:0][DWID-1:0]    cub_crbr_cflow_data_in,
    input  logic [CH_IN-1:0]              cub_crbr_cflow_valid_in,
    output logic [CH_IN-1:0]              cub_crbr_cflow_ready_out,
    output logic [CH_OUT-1:0][DWID-1:0]   cub_crbr_cflow_data_out,
    output logic [CH_OUT-1:0]             cub_crbr_cflow_valid_out,
    input  logic [CH_OUT-1:0]             cub_crbr_cflow_ready_in
);

    localparam int IDX_W = (CH_IN > 1) ? $clog2(CH_IN) : 1;

    crbr_state_e                  state_q;
    logic                         busy_q;
    logic [CH_OUT-1:0][CH_IN-1:0] active_q;
    logic [CH_OUT-1:0][CH_IN-1:0] capt_q;

    logic [CH_OUT-1:0] sel_vld;
    logic [IDX_W-1:0]  sel_idx [CH_OUT];
    logic [CH_IN-1:0]  ready;
    logic [CH_OUT-1:0] push, pop, fifo_full, fifo_empty;
    logic [DWID-1:0]   push_data [CH_OUT];
    logic              all_empty;

    // Lowest-index source in each active row wins the sink.
    always_comb begin
        // NOTE: every output gets a default before the loops so no path infers a latch.
        sel_vld = '0;
        for (int o = 0; o < CH_OUT; o++) begin
            sel_idx[o] = '0;
            for (int i = CH_IN - 1; i >= 0; i--) begin
                if (active_q[o][i]) begin
                    sel_vld[o] = 1'b1;
                    sel_idx[o] = IDX_W'(i);
                end
            end
        end
    end

    // A source is held off if any sink it feeds is full, so broadcasts are all-or-nothing.
    always_comb begin
        for (int i = 0; i < CH_IN; i++) begin
            ready[i] = (state_q == RUN) && !cub_crbr_cfg_load;
            for (int o = 0; o < CH_OUT; o++) begin
                if (sel_vld[o] && (sel_idx[o] == IDX_W'(i)) && fifo_full[o]) begin
                    ready[i] = 1'b0;
                end
            end
        end
    end

    always_comb begin
        for (int o = 0; o < CH_OUT; o++) begin
            push_data[o] = cub_crbr_cflow_data_in[sel_idx[o]];
            push[o]      = sel_vld[o] && cub_crbr_cflow_valid_in[sel_idx[o]]
                           && ready[sel_idx[o]];
        end
    end

    assign cub_crbr_cflow_ready_out = ready;
    assign cub_crbr_cflow_valid_out = ~fifo_empty;
    assign pop                      = ~fifo_empty & cub_crbr_cflow_ready_in;
    assign all_empty                = &fifo_empty;
    assign cub_crbr_cfg_busy        = busy_q;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (rst) begin
            state_q  <= RUN;
            busy_q   <= 1'b0;
            active_q <= '0;
            capt_q   <= '0;
        end else begin
            case (state_q)
                RUN: begin
                    if (cub_crbr_cfg_load) begin
                        capt_q  <= cub_crbr_cfg_bitmask;
                        state_q <= DRAIN;
                        busy_q  <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (all_empty) begin
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    active_q <= capt_q;
                    state_q  <= RUN;
                    busy_q   <= 1'b0;
                end
                default: begin
                    state_q <= RUN;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    for (genvar o = 0; o < CH_OUT; o++) begin : g_sink
        cub_crbr_fifo #(
            .DWID       (DWID),
            .FIFO_DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk     (clk),
            .rst     (rst),
            .push_i  (push[o]),
            .data_i  (push_data[o]),
            .pop_i   (pop[o]),
            .full_o  (fifo_full[o]),
            .empty_o (fifo_empty[o]),
            .head_o  (cub_crbr_cflow_data_out[o])
        );
    end

endmodule

// File: tb/tb_cub_crbr_rx.sv
// Bench for cub_crbr_rx: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_cub_crbr_rx;

    localparam int DWID    = 32;
    localparam int CH_IN   = 5;
    localparam int CH_OUT  = 5;
    localparam int DEPTH   = 4;
    localparam int M_RUN   = 0;
    localparam int M_DRAIN = 1;
    localparam int M_LOAD  = 2;

    logic                         clk = 1'b0;
    logic                         rst;
    logic [CH_OUT-1:0][CH_IN-1:0] cfg_bitmask;
    logic                         cfg_load;
    logic                         busy;
    logic [CH_IN-1:0][DWID-1:0]   data_in;
    logic [CH_IN-1:0]             valid_in;
    logic [CH_IN-1:0]             ready_out;
    logic [CH_OUT-1:0][DWID-1:0]  data_out;
    logic [CH_OUT-1:0]            valid_out;
    logic [CH_OUT-1:0]            ready_in;

    always #5 clk = ~clk;

    cub_crbr_rx #(
        .DWID       (DWID),
        .CH_IN      (CH_IN),
        .CH_OUT     (CH_OUT),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk                      (clk),
        .rst                      (rst),
        .cub_crbr_cfg_bitmask     (cfg_bitmask),
        .cub_crbr_cfg_load        (cfg_load),
        .cub_crbr_cfg_busy        (busy),
        .cub_crbr_cflow_data_in   (data_in),
        .cub_crbr_cflow_valid_in  (valid_in),
        .cub_crbr_cflow_ready_out (ready_out),
        .cub_crbr_cflow_data_out  (data_out),
        .cub_crbr_cflow_valid_out (valid_out),
        .cub_crbr_cflow_ready_in  (ready_in)
    );

    int n_checks = 0;
    int n_err    = 0;

    // Reference model: one queue per sink plus the two masks and the mode.
    logic [DWID-1:0]              mq [CH_OUT][$];
    logic [CH_OUT-1:0][CH_IN-1:0] m_active;
    logic [CH_OUT-1:0][CH_IN-1:0] m_capt;
    int                           m_mode = M_RUN;
    bit                           known  = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int sel_of(input int o);
        for (int i = 0; i < CH_IN; i++) begin
            if (m_active[o][i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [CH_IN-1:0] exp_ready();
        logic [CH_IN-1:0] r;
        int s;
        if (m_mode != M_RUN || cfg_load) return '0;
        r = '1;
        for (int o = 0; o < CH_OUT; o++) begin
            s = sel_of(o);
            if (s >= 0 && mq[o].size() >= DEPTH) r[s] = 1'b0;
        end
        return r;
    endfunction

    // One clock cycle: compare outputs to the model, advance the model, cross the edge.
    task automatic tick();
        logic [CH_IN-1:0] rdy;
        bit all_empty;
        int s;
        #1;
        rdy = exp_ready();
        if (known) begin
            for (int o = 0; o < CH_OUT; o++) begin
                check($sformatf("valid_out[%0d]", o), 64'(valid_out[o]), 64'(mq[o].size() > 0));
                if (mq[o].size() > 0)
                    check($sformatf("data_out[%0d]", o), 64'(data_out[o]), 64'(mq[o][0]));
            end
            check("ready_out", 64'(ready_out), 64'(rdy));
            check("cfg_busy", 64'(busy), 64'(m_mode != M_RUN));
        end
        if (rst) begin
            for (int o = 0; o < CH_OUT; o++) mq[o].delete();
            m_active = '0;
            m_capt   = '0;
            m_mode   = M_RUN;
            known    = 1'b1;
        end else if (known) begin
            all_empty = 1'b1;
            for (int o = 0; o < CH_OUT; o++) if (mq[o].size() > 0) all_empty = 1'b0;
            for (int o = 0; o < CH_OUT; o++) begin
                if (mq[o].size() > 0 && ready_in[o]) void'(mq[o].pop_front());
            end
            for (int o = 0; o < CH_OUT; o++) begin
                s = sel_of(o);
                if (s >= 0 && valid_in[s] && rdy[s]) mq[o].push_back(data_in[s]);
            end
            case (m_mode)
                M_RUN:   if (cfg_load) begin m_capt = cfg_bitmask; m_mode = M_DRAIN; end
                M_DRAIN: if (all_empty) m_mode = M_LOAD;
                default: begin m_active = m_capt; m_mode = M_RUN; end
            endcase
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        valid_in = '0;
        data_in  = '0;
        ready_in = '0;
        cfg_load = 1'b0;
    endtask

    task automatic reconfig(input logic [CH_OUT-1:0][CH_IN-1:0] mask);
        valid_in    = '0;
        ready_in    = '1;
        cfg_bitmask = mask;
        cfg_load    = 1'b1;
        tick();
        cfg_load = 1'b0;
        for (int n = 0; n < 40 && m_mode != M_RUN; n++) tick();
        #1 check("reconfig_done", 64'(busy), 64'd0);
        ready_in = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [CH_OUT-1:0][CH_IN-1:0] m;
        int pops, busy_cycles;
        bit running;

        rst = 1'b1;
        cfg_bitmask = '0;
        idle();
        @(negedge clk);
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("rst_ready_out", 64'(ready_out), 64'h1f);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_valid_out", 64'(valid_out), 64'd0);
        check("rst_data_out", 64'(data_out), 64'd0);

        // Unicast: source 0 -> sink 2.
        m = '0; m[2] = 5'b00001;
        reconfig(m);
        valid_in[0] = 1'b1; data_in[0] = 32'hA5;
        #1 check("uni_ready", 64'(ready_out[0]), 64'd1);
        tick();
        valid_in = '0;
        #1;
        check("uni_valid", 64'(valid_out[2]), 64'd1);
        check("uni_data", 64'(data_out[2]), 64'hA5);
        ready_in[2] = 1'b1;
        tick();
        #1 check("uni_popped", 64'(valid_out[2]), 64'd0);
        ready_in = '0;

        // Broadcast source 1 -> sinks 0 and 1 with both sinks stalled.
        m = '0; m[0] = 5'b00010; m[1] = 5'b00010;
        reconfig(m);
        for (int k = 0; k < 5; k++) begin
            valid_in[1] = 1'b1; data_in[1] = 32'(100 + k);
            #1 check($sformatf("bc_ready_%0d", k), 64'(ready_out[1]), (k < 4) ? 64'd1 : 64'd0);
            tick();
        end
        valid_in = '0;
        ready_in[1:0] = 2'b11;
        for (int k = 0; k < 4; k++) begin
            #1;
            check($sformatf("bc_s0_%0d", k), 64'(data_out[0]), 64'(100 + k));
            check($sformatf("bc_s1_%0d", k), 64'(data_out[1]), 64'(100 + k));
            tick();
        end
        #1 check("bc_no_fifth", 64'(valid_out[1:0]), 64'd0);
        ready_in = '0;

        // Conflict: sources 2 and 3 both in row 3; source 2 wins.
        m = '0; m[3] = 5'b01100;
        reconfig(m);
        valid_in[2] = 1'b1; data_in[2] = 32'h22;
        valid_in[3] = 1'b1; data_in[3] = 32'h33;
        #1;
        check("cf_ready2", 64'(ready_out[2]), 64'd1);
        check("cf_ready3", 64'(ready_out[3]), 64'd1);
        tick();
        valid_in = '0;
        #1 check("cf_data", 64'(data_out[3]), 64'h22);
        ready_in[3] = 1'b1;
        tick();
        #1 check("cf_single", 64'(valid_out[3]), 64'd0);
        ready_in = '0;

        // Drain: three entries queued in sink 0, then a reconfiguration to source 2.
        m = '0; m[0] = 5'b00001;
        reconfig(m);
        for (int k = 0; k < 3; k++) begin
            valid_in[0] = 1'b1; data_in[0] = 32'(32'h40 + k);
            tick();
        end
        valid_in = '0;
        m = '0; m[0] = 5'b00100;
        cfg_bitmask = m; cfg_load = 1'b1; ready_in[0] = 1'b1;
        #1 check("drain_ld_ready", 64'(ready_out), 64'd0);
        pops = valid_out[0] ? 1 : 0;
        tick();
        cfg_load = 1'b0;
        busy_cycles = 0;
        running = 1'b1;
        for (int n = 0; n < 20 && running; n++) begin
            #1;
            if (!busy) begin
                running = 1'b0;
            end else begin
                busy_cycles++;
                check("drain_ready", 64'(ready_out), 64'd0);
                if (valid_out[0]) pops++;
                tick();
            end
        end
        check("drain_pops", 64'(pops), 64'd3);
        check("drain_busy_cycles", 64'(busy_cycles), 64'd4);
        ready_in = '0;
        valid_in[2] = 1'b1; data_in[2] = 32'h77;
        check("new_mask_ready", 64'(ready_out[2]), 64'd1);
        tick();
        valid_in = '0;
        #1;
        check("new_mask_valid", 64'(valid_out[0]), 64'd1);
        check("new_mask_data", 64'(data_out[0]), 64'h77);
        ready_in = '1;
        tick();
        ready_in = '0;

        // Wrap and streaming: source 0 -> sink 4, ten beats with the sink always ready.
        m = '0; m[4] = 5'b00001;
        reconfig(m);
        ready_in[4] = 1'b1;
        for (int k = 0; k < 10; k++) begin
            valid_in[0] = 1'b1; data_in[0] = 32'(k);
            #1;
            check($sformatf("wrap_ready_%0d", k), 64'(ready_out[0]), 64'd1);
            if (k > 0) check($sformatf("wrap_data_%0d", k - 1), 64'(data_out[4]), 64'(k - 1));
            tick();
        end
        valid_in = '0;
        #1 check("wrap_data_9", 64'(data_out[4]), 64'd9);
        tick();
        #1 check("wrap_empty", 64'(valid_out[4]), 64'd0);
        ready_in = '0;

        // Reset while draining with two entries queued.
        m = '0; m[0] = 5'b00001;
        reconfig(m);
        for (int k = 0; k < 2; k++) begin
            valid_in[0] = 1'b1; data_in[0] = 32'(32'h90 + k);
            tick();
        end
        valid_in = '0;
        m = '0; m[1] = 5'b00001;
        cfg_bitmask = m; cfg_load = 1'b1;
        tick();
        cfg_load = 1'b0;
        #1 check("rd_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("rd_valid_out", 64'(valid_out), 64'd0);
        check("rd_busy_clr", 64'(busy), 64'd0);
        check("rd_ready_out", 64'(ready_out), 64'h1f);
        check("rd_data_out", 64'(data_out), 64'd0);
        valid_in = '1;
        for (int i = 0; i < CH_IN; i++) data_in[i] = $urandom();
        tick();
        valid_in = '0;
        #1 check("rd_mask_zero", 64'(valid_out), 64'd0);

        // Randomized traffic, reconfigurations and occasional resets.
        for (int it = 0; it < 800; it++) begin
            for (int i = 0; i < CH_IN; i++) data_in[i] = $urandom();
            valid_in = CH_IN'($urandom());
            ready_in = ((it % 100) < 30) ? '0 : (CH_OUT'($urandom()) | CH_OUT'($urandom()));
            cfg_load = ($urandom_range(0, 24) == 0);
            if (cfg_load) cfg_bitmask = (CH_OUT * CH_IN)'($urandom());
            rst = ($urandom_range(0, 299) == 0);
            tick();
        end
        rst = 1'b0;
        idle();
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
